// File: rtl/branch_result_sender_if.sv
// Predictor update bundle: execution-lane records in, brResult records out,
// plus the producer-side status (ready, occupancy, sticky overflow).
interface branch_result_sender_if #(
    parameter int INT_ISSUE_WIDTH = 2,
    parameter int QUEUE_DEPTH     = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int META_WIDTH      = 40
);
    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);

    logic [INT_ISSUE_WIDTH-1:0]                 exValid;
    logic [INT_ISSUE_WIDTH-1:0][ADDR_WIDTH-1:0] exAddr;
    logic [INT_ISSUE_WIDTH-1:0]                 exTaken;
    logic [INT_ISSUE_WIDTH-1:0]                 exIsCondBr;
    logic [INT_ISSUE_WIDTH-1:0]                 exMispred;
    logic [INT_ISSUE_WIDTH-1:0][META_WIDTH-1:0] exMeta;
    logic                                       exReady;
    logic                                       updateHold;

    logic [INT_ISSUE_WIDTH-1:0]                 brValid;
    logic [INT_ISSUE_WIDTH-1:0][ADDR_WIDTH-1:0] brAddr;
    logic [INT_ISSUE_WIDTH-1:0]                 brExecTaken;
    logic [INT_ISSUE_WIDTH-1:0]                 brIsCondBr;
    logic [INT_ISSUE_WIDTH-1:0]                 brMispred;
    logic [INT_ISSUE_WIDTH-1:0][META_WIDTH-1:0] brMeta;
    logic [OCC_W-1:0]                           occupancy;
    logic                                       overflow;

    // Sender side: consumes execution records, produces predictor updates.
    modport master (
        input  exValid, exAddr, exTaken, exIsCondBr, exMispred, exMeta, updateHold,
        output exReady, brValid, brAddr, brExecTaken, brIsCondBr, brMispred, brMeta,
        output occupancy, overflow
    );

    // Environment side: writeback stage plus predictor.
    modport slave (
        output exValid, exAddr, exTaken, exIsCondBr, exMispred, exMeta, updateHold,
        input  exReady, brValid, brAddr, brExecTaken, brIsCondBr, brMispred, brMeta,
        input  occupancy, overflow
    );
endinterface

// File: rtl/branch_result_sender.sv
// Branch-result FIFO feeding the predictor update port. Two records in and
// up to two out per cycle; a same-cycle pair hitting one PHT index is split
// so the predictor never sees two writes to the same entry.
module branch_result_sender #(
    parameter int INT_ISSUE_WIDTH     = 2,
    parameter int QUEUE_DEPTH         = 8,
    parameter int ADDR_WIDTH          = 32,
    parameter int INSN_ADDR_BIT_WIDTH = 2,
    parameter int PHT_INDEX_BITS      = 8,
    parameter int META_WIDTH          = 40
) (
    input logic                     clk,
    input logic                     rst,
    branch_result_sender_if.master  bus
);
    localparam int PW     = $clog2(QUEUE_DEPTH);
    localparam int CW     = $clog2(QUEUE_DEPTH + 1);
    localparam int IDX_LO = INSN_ADDR_BIT_WIDTH;
    localparam int IDX_HI = INSN_ADDR_BIT_WIDTH + PHT_INDEX_BITS - 1;
    localparam logic [CW-1:0] READY_MAX = CW'(QUEUE_DEPTH - 2);

    logic [ADDR_WIDTH-1:0]  addr_q [QUEUE_DEPTH];
    logic [META_WIDTH-1:0]  meta_q [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] taken_q;
    logic [QUEUE_DEPTH-1:0] cond_q;
    logic [QUEUE_DEPTH-1:0] mispred_q;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW-1:0] head_p1, wr_ptr1;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic                      ready;
    logic                      out_v0, out_v1;
    logic [1:0]                enq_n, deq_n;
    logic [PHT_INDEX_BITS-1:0] idx0, idx1;

    // Queue control: readiness from registered count only, dequeue split on PHT index collision.
    always_comb begin
        ready      = (count_q <= READY_MAX);
        head_p1    = head_q + PW'(1);
        idx0       = addr_q[head_q][IDX_HI:IDX_LO];
        idx1       = addr_q[head_p1][IDX_HI:IDX_LO];
        out_v0     = !bus.updateHold && (count_q != '0);
        out_v1     = !bus.updateHold && (count_q >= CW'(2)) && (idx0 != idx1);
        deq_n      = {1'b0, out_v0} + {1'b0, out_v1};
        enq_n      = ready ? ({1'b0, bus.exValid[0]} + {1'b0, bus.exValid[1]}) : 2'd0;
        wr_ptr1    = tail_q + PW'(bus.exValid[0]);
        head_d     = head_q + PW'(deq_n);
        tail_d     = tail_q + PW'(enq_n);
        count_d    = count_q + CW'(enq_n) - CW'(deq_n);
        overflow_d = overflow_q | (!ready && (|bus.exValid));
    end

    // Pointer, count and sticky overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; valid lanes are compacted so a lone lane 1 lands at the tail.
    always_ff @(posedge clk) begin
        if (ready && bus.exValid[0]) begin
            addr_q[tail_q]    <= bus.exAddr[0];
            meta_q[tail_q]    <= bus.exMeta[0];
            taken_q[tail_q]   <= bus.exTaken[0];
            cond_q[tail_q]    <= bus.exIsCondBr[0];
            mispred_q[tail_q] <= bus.exMispred[0];
        end
        if (ready && bus.exValid[1]) begin
            addr_q[wr_ptr1]    <= bus.exAddr[1];
            meta_q[wr_ptr1]    <= bus.exMeta[1];
            taken_q[wr_ptr1]   <= bus.exTaken[1];
            cond_q[wr_ptr1]    <= bus.exIsCondBr[1];
            mispred_q[wr_ptr1] <= bus.exMispred[1];
        end
    end

    // Update-port outputs; data lanes are zeroed whenever their valid is low.
    always_comb begin
        bus.exReady        = ready;
        bus.occupancy      = count_q;
        bus.overflow       = overflow_q;
        bus.brValid        = {out_v1, out_v0};
        bus.brAddr[0]      = out_v0 ? addr_q[head_q]     : '0;
        bus.brMeta[0]      = out_v0 ? meta_q[head_q]     : '0;
        bus.brExecTaken[0] = out_v0 & taken_q[head_q];
        bus.brIsCondBr[0]  = out_v0 & cond_q[head_q];
        bus.brMispred[0]   = out_v0 & mispred_q[head_q];
        bus.brAddr[1]      = out_v1 ? addr_q[head_p1]    : '0;
        bus.brMeta[1]      = out_v1 ? meta_q[head_p1]    : '0;
        bus.brExecTaken[1] = out_v1 & taken_q[head_p1];
        bus.brIsCondBr[1]  = out_v1 & cond_q[head_p1];
        bus.brMispred[1]   = out_v1 & mispred_q[head_p1];
    end
endmodule

// File: tb/tb_branch_result_sender.sv
module tb_branch_result_sender;
    localparam int QD = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic        taken;
        logic        cond;
        logic        mis;
        logic [39:0] meta;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    rec_t mq[$];
    bit   m_ovf;

    branch_result_sender_if #(.INT_ISSUE_WIDTH(2), .QUEUE_DEPTH(QD), .ADDR_WIDTH(32), .META_WIDTH(40)) bus ();

    branch_result_sender #(
        .INT_ISSUE_WIDTH(2), .QUEUE_DEPTH(QD), .ADDR_WIDTH(32),
        .INSN_ADDR_BIT_WIDTH(2), .PHT_INDEX_BITS(8), .META_WIDTH(40)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.exValid    = '0;
        bus.exAddr     = '0;
        bus.exTaken    = '0;
        bus.exIsCondBr = '0;
        bus.exMispred  = '0;
        bus.exMeta     = '0;
    endtask

    task automatic set_lane(input int l, input logic [31:0] a, input logic t,
                            input logic c, input logic m, input logic [39:0] md);
        bus.exValid[l]    = 1'b1;
        bus.exAddr[l]     = a;
        bus.exTaken[l]    = t;
        bus.exIsCondBr[l] = c;
        bus.exMispred[l]  = m;
        bus.exMeta[l]     = md;
    endtask

    // Reference queue advanced by one clock using the current inputs.
    task automatic model_step();
        int n;
        bit rdy;
        rec_t r;
        n   = 0;
        rdy = (mq.size() <= QD - 2);
        if (!bus.updateHold && mq.size() >= 1) begin
            n = 1;
            if (mq.size() >= 2 && mq[0].addr[9:2] != mq[1].addr[9:2]) n = 2;
        end
        repeat (n) void'(mq.pop_front());
        for (int l = 0; l < 2; l++) begin
            if (bus.exValid[l]) begin
                if (rdy) begin
                    r.addr  = bus.exAddr[l];
                    r.taken = bus.exTaken[l];
                    r.cond  = bus.exIsCondBr[l];
                    r.mis   = bus.exMispred[l];
                    r.meta  = bus.exMeta[l];
                    mq.push_back(r);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({bus.exReady, bus.occupancy, bus.brValid, bus.overflow, bus.brAddr} !==
                {1'b1, 4'd0, 2'b00, 1'b0, 64'd0}) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: ready=%b occ=%0d brValid=%b ovf=%b brAddr=%h want 1/0/00/0/0",
                         c, bus.exReady, bus.occupancy, bus.brValid, bus.overflow, bus.brAddr);
            end
            tick();
        end
    endtask

    task automatic test_pair();
        set_lane(0, 32'h100, 1'b1, 1'b1, 1'b0, 40'hAA_1234_5678);
        set_lane(1, 32'h104, 1'b0, 1'b1, 1'b1, 40'h55_8765_4321);
        tick();
        clear_inputs();
        @(negedge clk);
        total++;
        if ({bus.brValid, bus.brAddr[0], bus.brAddr[1], bus.brExecTaken, bus.brMispred} !==
            {2'b11, 32'h100, 32'h104, 2'b01, 2'b10}) begin
            bad++;
            $display("FAIL pair_out: valid=%b a0=%h a1=%h tk=%b mis=%b want 11 100 104 01 10",
                     bus.brValid, bus.brAddr[0], bus.brAddr[1], bus.brExecTaken, bus.brMispred);
        end
        total++;
        if ({bus.brMeta[0], bus.brMeta[1]} !== {40'hAA_1234_5678, 40'h55_8765_4321}) begin
            bad++;
            $display("FAIL pair_meta: m0=%h m1=%h want aa12345678 5587654321", bus.brMeta[0], bus.brMeta[1]);
        end
        tick();
        @(negedge clk);
        total++;
        if ({bus.occupancy, bus.brValid} !== {4'd0, 2'b00}) begin
            bad++;
            $display("FAIL pair_drained: occ=%0d valid=%b want 0 00", bus.occupancy, bus.brValid);
        end
        tick();
    endtask

    task automatic test_same_index();
        logic [31:0] exp_a [2];
        exp_a[0] = 32'h100;
        exp_a[1] = 32'h500;
        set_lane(0, 32'h100, 1'b1, 1'b1, 1'b0, 40'h1);
        set_lane(1, 32'h500, 1'b1, 1'b1, 1'b0, 40'h2);
        tick();
        clear_inputs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({bus.brValid, bus.brAddr[0], bus.occupancy} !== {2'b01, exp_a[c], 4'(2 - c)}) begin
                bad++;
                $display("FAIL same_index cycle %0d: valid=%b a0=%h occ=%0d want 01 %h %0d",
                         c + 1, bus.brValid, bus.brAddr[0], bus.occupancy, exp_a[c], 2 - c);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (bus.occupancy !== 4'd0) begin
            bad++;
            $display("FAIL same_index_empty: occ=%0d want 0", bus.occupancy);
        end
        tick();
    endtask

    task automatic test_hold_overflow();
        int i;
        bus.updateHold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_lane(0, 32'h1000 + 32'(8 * k), 1'b0, 1'b1, 1'b0, 40'(k));
            set_lane(1, 32'h1004 + 32'(8 * k), 1'b1, 1'b1, 1'b0, 40'(k + 16));
            tick();
            clear_inputs();
            @(negedge clk);
            total++;
            if ({bus.occupancy, bus.brValid, bus.exReady} !== {4'(2 * (k + 1)), 2'b00, 1'b1}) begin
                bad++;
                $display("FAIL hold_fill step %0d: occ=%0d valid=%b ready=%b want %0d 00 1",
                         k, bus.occupancy, bus.brValid, bus.exReady, 2 * (k + 1));
            end
        end
        tick();
        set_lane(0, 32'h1018, 1'b0, 1'b0, 1'b0, 40'h7);
        tick();
        clear_inputs();
        @(negedge clk);
        total++;
        if ({bus.occupancy, bus.exReady, bus.overflow} !== {4'd7, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL hold_seven: occ=%0d ready=%b ovf=%b want 7 0 0", bus.occupancy, bus.exReady, bus.overflow);
        end
        tick();
        set_lane(0, 32'h2000, 1'b1, 1'b1, 1'b1, 40'hDEAD);
        set_lane(1, 32'h2004, 1'b1, 1'b1, 1'b1, 40'hBEEF);
        tick();
        clear_inputs();
        @(negedge clk);
        total++;
        if ({bus.occupancy, bus.overflow, bus.brValid} !== {4'd7, 1'b1, 2'b00}) begin
            bad++;
            $display("FAIL overflow_drop: occ=%0d ovf=%b valid=%b want 7 1 00", bus.occupancy, bus.overflow, bus.brValid);
        end
        tick();
        bus.updateHold = 1'b0;
        i = 0;
        for (int c = 0; c < 6 && i < 7; c++) begin
            @(negedge clk);
            total++;
            if (bus.brValid[0] !== 1'b1 || bus.brAddr[0] !== 32'h1000 + 32'(4 * i)) begin
                bad++;
                $display("FAIL drain_lane0 rec %0d: valid=%b addr=%h want 1 %h",
                         i, bus.brValid[0], bus.brAddr[0], 32'h1000 + 32'(4 * i));
            end
            if (i + 1 < 7) begin
                total++;
                if (bus.brValid[1] !== 1'b1 || bus.brAddr[1] !== 32'h1000 + 32'(4 * (i + 1))) begin
                    bad++;
                    $display("FAIL drain_lane1 rec %0d: valid=%b addr=%h want 1 %h",
                             i + 1, bus.brValid[1], bus.brAddr[1], 32'h1000 + 32'(4 * (i + 1)));
                end
            end
            i += 2;
            tick();
        end
        @(negedge clk);
        total++;
        if ({bus.occupancy, bus.overflow, bus.brValid} !== {4'd0, 1'b1, 2'b00}) begin
            bad++;
            $display("FAIL drain_end: occ=%0d ovf=%b valid=%b want 0 1 00", bus.occupancy, bus.overflow, bus.brValid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.updateHold = 1'b1;
        set_lane(0, 32'h3000, 1'b1, 1'b1, 1'b0, 40'h1);
        set_lane(1, 32'h3004, 1'b1, 1'b1, 1'b0, 40'h2);
        tick();
        set_lane(0, 32'h3008, 1'b1, 1'b1, 1'b0, 40'h3);
        set_lane(1, 32'h300C, 1'b1, 1'b1, 1'b0, 40'h4);
        tick();
        clear_inputs();
        set_lane(0, 32'h3010, 1'b1, 1'b1, 1'b0, 40'h5);
        tick();
        clear_inputs();
        bus.updateHold = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.brValid, bus.occupancy} !== {2'b11, 4'd5}) begin
            bad++;
            $display("FAIL pre_reset: valid=%b occ=%0d want 11 5", bus.brValid, bus.occupancy);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({bus.brValid, bus.occupancy, bus.overflow, bus.exReady} !== {2'b00, 4'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL async_reset: valid=%b occ=%0d ovf=%b ready=%b want 00 0 0 1",
                     bus.brValid, bus.occupancy, bus.overflow, bus.exReady);
        end
        tick();
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({bus.brValid, bus.occupancy} !== {2'b00, 4'd0}) begin
                bad++;
                $display("FAIL post_reset cycle %0d: valid=%b occ=%0d want 00 0", c, bus.brValid, bus.occupancy);
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit   ev0, ev1;
        rec_t g0, g1, e0, e1;
        for (int c = 0; c < 600; c++) begin
            bus.updateHold = ($urandom_range(0, 3) == 0);
            for (int l = 0; l < 2; l++) begin
                if (bus.exReady ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0))
                    set_lane(l, $urandom & 32'h0000_F30C, 1'($urandom), 1'($urandom), 1'($urandom),
                             {8'($urandom), 32'($urandom)});
                else
                    bus.exValid[l] = 1'b0;
            end
            @(negedge clk);
            ev0 = !bus.updateHold && mq.size() >= 1;
            ev1 = !bus.updateHold && mq.size() >= 2 && mq[0].addr[9:2] != mq[1].addr[9:2];
            e0  = ev0 ? mq[0] : '0;
            e1  = ev1 ? mq[1] : '0;
            g0  = {bus.brAddr[0], bus.brExecTaken[0], bus.brIsCondBr[0], bus.brMispred[0], bus.brMeta[0]};
            g1  = {bus.brAddr[1], bus.brExecTaken[1], bus.brIsCondBr[1], bus.brMispred[1], bus.brMeta[1]};
            total++;
            if ({bus.occupancy, bus.exReady, bus.overflow} !== {4'(mq.size()), mq.size() <= QD - 2, m_ovf}) begin
                bad++;
                $display("FAIL rand_status cycle %0d: occ=%0d ready=%b ovf=%b want %0d %b %b",
                         c, bus.occupancy, bus.exReady, bus.overflow, mq.size(), mq.size() <= QD - 2, m_ovf);
            end
            total++;
            if ({bus.brValid, g0, g1} !== {ev1, ev0, e0, e1}) begin
                bad++;
                $display("FAIL rand_out cycle %0d: valid=%b l0=%h l1=%h want %b%b %h %h",
                         c, bus.brValid, g0, g1, ev1, ev0, e0, e1);
            end
            model_step();
            tick();
        end
        clear_inputs();
        bus.updateHold = 1'b0;
    endtask

    initial begin
        clear_inputs();
        bus.updateHold = 1'b0;
        m_ovf = 1'b0;
        #12 rst = 1'b0;
        tick();
        test_reset();
        test_pair();
        test_same_index();
        test_hold_overflow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
